// File: rtl/riscv_lsu.sv
// riscv_lsu: load-store unit between the core data port and a word-wide data
// memory. Stores are lane-aligned into a byte-enabled word write; loads are
// extracted from the returned word and sign/zero-extended. The core is held
// stalled until the memory handshake completes, misaligned accesses are
// flagged without being issued, and a stuck bus is aborted after a timeout.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    // Counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        size_q;      // access size kept for load extension
    logic [1:0]        lane_q;      // byte offset kept for load lane select
    logic              is_half, is_word;
    logic              accept, finish_ok, abort, timeout_hit;
    logic [3:0]        be_lane;
    logic [31:0]       wd_lane;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    // Alignment check on the live request; byte accesses can never be misaligned.
    always_comb begin
        is_half      = (core_size_i == SZ_H) || (core_size_i == SZ_HU);
        is_word      = (core_size_i == SZ_W);
        misaligned_o = core_req_i & ((is_half & core_addr_i[0]) |
                                     (is_word & (|core_addr_i[1:0])));
    end

    // Store lane placement: replicate data across lanes, enable only the target bytes.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        be_lane = 4'b1111;
        wd_lane = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                be_lane = 4'b0001 << core_addr_i[1:0];
                wd_lane = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_lane = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_lane = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_lane = 4'b1111;
                wd_lane = core_wd_i;
            end
        endcase
        if (!core_we_i) begin
            be_lane = 4'b1111;
        end
    end

    // Load extraction from the returned word using the registered offset and size.
    always_comb begin
        byte_sel  = mem_rd_i[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        load_data = mem_rd_i;
        case (size_q)
            SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   load_data = {24'b0, byte_sel};
            SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   load_data = {16'b0, half_sel};
            default: load_data = mem_rd_i;
        endcase
    end

    // Timeout fires only when enabled and the BUSY counter reaches its last value.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and transaction events; ready wins over a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish_ok = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_req_i && !misaligned_o) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready_i) begin
                    finish_ok = 1'b1;
                    state_d   = S_DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Core is released only in DONE, or immediately for a rejected misaligned access.
    always_comb begin
        core_stall_o = core_req_i & ~misaligned_o & (state_q != S_DONE);
    end

    // Memory request fields, load result, error pulse and timeout counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0;
            mem_addr_o <= 32'b0;
            mem_wd_o   <= 32'b0;
            core_rd_o  <= 32'b0;
            bus_err_o  <= 1'b0;
            cnt_q      <= '0;
            size_q     <= 3'b0;
            lane_q     <= 2'b0;
        end else begin
            bus_err_o <= 1'b0;
            if (accept) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= core_we_i;
                mem_be_o   <= be_lane;
                mem_addr_o <= {core_addr_i[31:2], 2'b00};
                mem_wd_o   <= wd_lane;
                size_q     <= core_size_i;
                lane_q     <= core_addr_i[1:0];
                cnt_q      <= '0;
            end
            if (finish_ok) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) begin
                    core_rd_o <= load_data;
                end
            end else if (abort) begin
                mem_req_o <= 1'b0;
                bus_err_o <= 1'b1;
                core_rd_o <= 32'b0;
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu. A vector table
// covers store lane placement and load extension; hand-written sequences cover
// wait states, timeout, ready-at-timeout, misalignment, core trap mid-access,
// back-to-back accesses and reset during BUSY. The DUT uses an 8-cycle timeout.
module tb_riscv_lsu;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int errors = 0;
    int checks = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .core_req_i  (core_req_i),
        .core_we_i   (core_we_i),
        .core_size_i (core_size_i),
        .core_addr_i (core_addr_i),
        .core_wd_i   (core_wd_i),
        .core_rd_o   (core_rd_o),
        .core_stall_o(core_stall_o),
        .misaligned_o(misaligned_o),
        .bus_err_o   (bus_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdw;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access from the IDLE request cycle through DONE. The memory model
    // answers after wait_n BUSY cycles, or never when a timeout is expected.
    task automatic run_txn(input string name, input vec_t v, input int wait_n, input bit exp_to);
        int busy_n = 0;
        int stall_n = 0;
        bit done = 1'b0;
        bit stable = 1'b1;
        @(negedge clk_i);
        check({name, ":idle_no_req"}, {31'b0, mem_req_o}, 32'd0);
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        mem_rd_i    = v.rdw;
        mem_ready_i = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            mem_ready_i = mem_req_o && !exp_to && (busy_n == wait_n);
            if (mem_req_o) begin
                busy_n++;
                if (mem_addr_o !== {v.addr[31:2], 2'b00} || mem_be_o !== v.be ||
                    mem_we_o !== v.we || (v.we && mem_wd_o !== v.exp_wd))
                    stable = 1'b0;
            end
            #1;
            if (core_stall_o) stall_n++;
            else done = 1'b1;
        end
        mem_ready_i = 1'b0;
        check({name, ":done_reached"}, {31'b0, done}, 32'd1);
        check({name, ":stall_cycles"}, stall_n, exp_to ? 1 + TO : 2 + wait_n);
        check({name, ":req_cycles"}, busy_n, exp_to ? TO : wait_n + 1);
        check({name, ":fields_stable"}, {31'b0, stable}, 32'd1);
        check({name, ":bus_err"}, {31'b0, bus_err_o}, {31'b0, exp_to});
        check({name, ":req_dropped"}, {31'b0, mem_req_o}, 32'd0);
        if (!v.we) check({name, ":rd"}, core_rd_o, exp_to ? 32'd0 : v.exp_rd);
    endtask

    // One quiet cycle with the request dropped.
    task automatic idle_cycle(input string name);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check({name, ":idle_stall"}, {31'b0, core_stall_o}, 32'd0);
        check({name, ":idle_buserr"}, {31'b0, bus_err_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // we, size, addr, wd, mem word, expected be, expected wd, expected rd
        vecs[0]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[1]  = '{1'b0, 3'd0, 32'h102, 32'h0,        32'h0080FF00, 4'b1111, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'd4, 32'h102, 32'h0,        32'h0080FF00, 4'b1111, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 3'd1, 32'h20A, 32'h1234BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[4]  = '{1'b1, 3'd1, 32'h200, 32'h0000CAFE, 32'h0,        4'b0011, 32'hCAFECAFE, 32'h0};
        vecs[5]  = '{1'b1, 3'd2, 32'h30C, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{1'b0, 3'd1, 32'h302, 32'h0,        32'h80017FFF, 4'b1111, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{1'b0, 3'd5, 32'h302, 32'h0,        32'h80017FFF, 4'b1111, 32'h0,        32'h00008001};
        vecs[8]  = '{1'b0, 3'd1, 32'h300, 32'h0,        32'h80017FFF, 4'b1111, 32'h0,        32'h00007FFF};
        vecs[9]  = '{1'b0, 3'd2, 32'h404, 32'h0,        32'h12345678, 4'b1111, 32'h0,        32'h12345678};
        vecs[10] = '{1'b0, 3'd0, 32'h401, 32'h0,        32'h12345678, 4'b1111, 32'h0,        32'h00000056};
        vecs[11] = '{1'b0, 3'd0, 32'h403, 32'h0,        32'hAABBCCF0, 4'b1111, 32'h0,        32'hFFFFFFAA};
        vecs[12] = '{1'b0, 3'd4, 32'h400, 32'h0,        32'hAABBCCF0, 4'b1111, 32'h0,        32'h000000F0};
        vecs[13] = '{1'b1, 3'd0, 32'h501, 32'h123456C3, 32'h0,        4'b0010, 32'hC3C3C3C3, 32'h0};

        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst:mem_req",  {31'b0, mem_req_o}, 32'd0);
        check("rst:mem_we",   {31'b0, mem_we_o}, 32'd0);
        check("rst:mem_be",   {28'b0, mem_be_o}, 32'd0);
        check("rst:mem_addr", mem_addr_o, 32'd0);
        check("rst:mem_wd",   mem_wd_o, 32'd0);
        check("rst:core_rd",  core_rd_o, 32'd0);
        check("rst:bus_err",  {31'b0, bus_err_o}, 32'd0);
        check("rst:stall",    {31'b0, core_stall_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Table: zero-wait stores and loads
        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
            idle_cycle($sformatf("vec%0d", i));
        end

        // Misaligned accesses are flagged, not issued, and do not stall
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd1; core_addr_i = 32'h203;
        #1;
        check("mis_lh:flag",  {31'b0, misaligned_o}, 32'd1);
        check("mis_lh:stall", {31'b0, core_stall_o}, 32'd0);
        core_we_i = 1'b1; core_size_i = 3'd2; core_addr_i = 32'h102;
        #1;
        check("mis_sw:flag",  {31'b0, misaligned_o}, 32'd1);
        core_size_i = 3'd5; core_addr_i = 32'h201; core_we_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("mis_lhu:flag",   {31'b0, misaligned_o}, 32'd1);
        check("mis:no_mem_req", {31'b0, mem_req_o}, 32'd0);
        core_size_i = 3'd1; core_addr_i = 32'h202;
        #1;
        check("aligned_lh:flag", {31'b0, misaligned_o}, 32'd0);
        core_req_i = 1'b0;
        #1;
        check("mis:no_req_flag", {31'b0, misaligned_o}, 32'd0);

        // Wait states, ready on the final timeout cycle, and a full timeout
        v = '{1'b0, 3'd2, 32'h600, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D};
        run_txn("lw_wait5", v, 5, 1'b0);
        idle_cycle("lw_wait5");
        v = '{1'b0, 3'd1, 32'h6A2, 32'h0, 32'h9ABC1234, 4'b1111, 32'h0, 32'hFFFF9ABC};
        run_txn("lh_ready_at_limit", v, TO - 1, 1'b0);
        idle_cycle("lh_ready_at_limit");
        v = '{1'b0, 3'd2, 32'h700, 32'h0, 32'h55555555, 4'b1111, 32'h0, 32'h0};
        run_txn("lw_timeout", v, 0, 1'b1);
        idle_cycle("lw_timeout");

        // Back-to-back: request held through DONE is taken only on the next IDLE
        v = '{1'b1, 3'd2, 32'h804, 32'h01020304, 32'h0, 4'b1111, 32'h01020304, 32'h0};
        run_txn("b2b_first", v, 1, 1'b0);
        v = '{1'b0, 3'd0, 32'h806, 32'h0, 32'h00EE0000, 4'b1111, 32'h0, 32'hFFFFFFEE};
        run_txn("b2b_second", v, 0, 1'b0);
        idle_cycle("b2b");

        // Core drops the request mid-BUSY; the access still finishes
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h900;
        mem_rd_i = 32'h11112222;
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check("trap:busy_req",   {31'b0, mem_req_o}, 32'd1);
        check("trap:stall_free", {31'b0, core_stall_o}, 32'd0);
        @(negedge clk_i);
        check("trap:req_held",   {31'b0, mem_req_o}, 32'd1);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        check("trap:req_done",   {31'b0, mem_req_o}, 32'd0);
        check("trap:no_err",     {31'b0, bus_err_o}, 32'd0);
        v = '{1'b0, 3'd4, 32'h903, 32'h0, 32'h7F000000, 4'b1111, 32'h0, 32'h0000007F};
        run_txn("after_trap", v, 2, 1'b0);
        idle_cycle("after_trap");

        // Reset asserted during BUSY of a store drops the request at once
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'hA00; core_wd_i = 32'h5555AAAA;
        @(negedge clk_i);
        check("rst_busy:req_before", {31'b0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_busy:req_dropped", {31'b0, mem_req_o}, 32'd0);
        check("rst_busy:be_cleared",  {28'b0, mem_be_o}, 32'd0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        rst_i = 1'b1;
        v = '{1'b0, 3'd2, 32'hA04, 32'h0, 32'h0BADCAFE, 4'b1111, 32'h0, 32'h0BADCAFE};
        run_txn("lw_after_rst", v, 1, 1'b0);
        idle_cycle("lw_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
